// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Provides access-size decode and misalignment detection helpers.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    // Undefined encodings fall back to a full word access.
    function automatic lsu_size_e decode_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            3'b000, 3'b100: sz = SZ_B;
            3'b001, 3'b101: sz = SZ_H;
            default:        sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (decode_size(f3))
            SZ_H:    mis = lo[0];
            SZ_W:    mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication,
// and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension; halfword lane uses addr_lo[1] only.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        case (decode_size(funct3))
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one sized bus transaction per memory instruction, stalling the PC.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] Mem_WrAddr,
    input  logic [DATA_W-1:0] Mem_WrData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              Fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [BE_W-1:0]   bus_be,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    lsu_state_e        state_r, state_next_s;
    logic              mem_req_s, misalign_s;
    logic [BE_W-1:0]   be_s;
    logic [DATA_W-1:0] wdata_s, rdata_ext_s;
    logic              bus_req_r, bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r, read_data_r;
    logic [BE_W-1:0]   bus_be_r;

    lsu_align u_align (
        .funct3    (funct3),
        .addr_lo   (Mem_WrAddr[1:0]),
        .wdata     (Mem_WrData),
        .rdata     (bus_rdata),
        .be        (be_s),
        .wdata_rep (wdata_s),
        .rdata_ext (rdata_ext_s)
    );

    // Request detection and optional misalignment qualification.
    always_comb begin
        mem_req_s = MemRead | MemWrite;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = is_misaligned(funct3, Mem_WrAddr[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a trapped access skips the bus phase.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_req_s) begin
                    state_next_s = misalign_s ? ST_DONE : ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Bus output registers and load-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wdata_r <= 32'h00000000;
            bus_be_r    <= 4'b0000;
            read_data_r <= 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_req_s && !misalign_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= MemWrite;
                        bus_addr_r  <= {Mem_WrAddr[ADDR_W-1:2], 2'b00};
                        bus_be_r    <= be_s;
                        bus_wdata_r <= wdata_s;
                    end else begin
                        bus_req_r <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (mem_req_s) begin
                            read_data_r <= 32'h00000000;
                        end
`endif
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            read_data_r <= rdata_ext_s;
                        end
                    end else begin
                        bus_req_r <= 1'b1;
                    end
                end
                default: bus_req_r <= 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_r;

    // Fault pulses for the DONE cycle of a trapped access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (state_r == ST_IDLE) && mem_req_s && misalign_s;
        end
    end

    assign Fault = fault_r;
`else
    assign Fault = 1'b0;
`endif

    assign Stall     = ((state_r == ST_IDLE) && mem_req_s) || (state_r == ST_REQ);
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;
    assign ReadData  = read_data_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table driven through a bus-slave loop,
// expected transactions held in a scoreboard queue, plus reset/trap sequences.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk, reset, MemRead, MemWrite, bus_ready;
    logic [2:0]  funct3;
    logic [31:0] Mem_WrAddr, Mem_WrData, ReadData, bus_addr, bus_wdata, bus_rdata;
    logic        Stall, Fault, bus_req, bus_we;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        int          waits;
        logic [3:0]  be;
        logic [31:0] baddr, bwd, rd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] baddr, bwd, rd;
        int          stall;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    lsu #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
        .ReadData(ReadData), .Stall(Stall), .Fault(Fault), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int waits, input logic [3:0] be,
                                input logic [31:0] baddr, input logic [31:0] bwd,
                                input logic [31:0] rd);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.waits = waits; v.be = be; v.baddr = baddr; v.bwd = bwd; v.rd = rd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   req_cycles;
        int   stall_cnt;
        bit   got;
        @(negedge clk);
        MemRead = v.mr; MemWrite = v.mw; funct3 = v.f3;
        Mem_WrAddr = v.addr; Mem_WrData = v.wd; bus_rdata = v.rdata; bus_ready = 1'b0;
        e.we = v.mw; e.be = v.be; e.baddr = v.baddr; e.bwd = v.bwd; e.rd = v.rd;
        e.stall = 2 + v.waits;
        sb_q.push_back(e);
        req_cycles = 0; stall_cnt = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (Stall) stall_cnt++;
            if (bus_req) begin
                chk("bus_addr", bus_addr, sb_q[0].baddr);
                chk("bus_be", {28'h0, bus_be}, {28'h0, sb_q[0].be});
                chk("bus_we", {31'h0, bus_we}, {31'h0, sb_q[0].we});
                chk("bus_wdata", bus_wdata, sb_q[0].bwd);
                bus_ready = (req_cycles == v.waits);
                if (bus_ready) got = 1'b1;
                req_cycles++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus_ready = 1'b0;
        chk("bus_timeout", {31'h0, got}, 32'h1);
        if (got) begin
            #1;
            e = sb_q.pop_front();
            chk("ReadData", ReadData, e.rd);
            chk("done_stall", {31'h0, Stall}, 32'h0);
            chk("done_req", {31'h0, bus_req}, 32'h0);
            chk("done_fault", {31'h0, Fault}, 32'h0);
            chk("stall_cycles", stall_cnt, e.stall);
        end else begin
            sb_q.delete();
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_stall", {31'h0, Stall}, 32'h0);
        chk("idle_req", {31'h0, bus_req}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        Mem_WrAddr = 32'h0; Mem_WrData = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;

        vecs.push_back(mk(1'b1, 1'b0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b0, F3_LB,  32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80));
        vecs.push_back(mk(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h100, 32'h0, 32'h00000080));
        vecs.push_back(mk(1'b0, 1'b1, F3_LH,  32'h202, 32'h1234ABCD, 32'h55555555, 0, 4'b1100, 32'h200, 32'hABCDABCD, 32'h00000080));
        vecs.push_back(mk(1'b1, 1'b0, F3_LW,  32'h100, 32'h0, 32'h0BADF00D, 3, 4'b1111, 32'h100, 32'h0, 32'h0BADF00D));
        vecs.push_back(mk(1'b1, 1'b0, F3_LH,  32'h302, 32'h0, 32'h80017FFF, 0, 4'b1100, 32'h300, 32'h0, 32'hFFFF8001));
        vecs.push_back(mk(1'b1, 1'b0, F3_LHU, 32'h302, 32'h0, 32'h80017FFF, 1, 4'b1100, 32'h300, 32'h0, 32'h00008001));
        vecs.push_back(mk(1'b1, 1'b0, F3_LB,  32'h001, 32'h0, 32'h00007F00, 1, 4'b0010, 32'h000, 32'h0, 32'h0000007F));
        vecs.push_back(mk(1'b0, 1'b1, F3_LB,  32'h407, 32'h000000A5, 32'h0, 0, 4'b1000, 32'h404, 32'hA5A5A5A5, 32'h0000007F));
        vecs.push_back(mk(1'b0, 1'b1, F3_LW,  32'h408, 32'hCAFEF00D, 32'h0, 2, 4'b1111, 32'h408, 32'hCAFEF00D, 32'h0000007F));
        vecs.push_back(mk(1'b1, 1'b1, F3_LW,  32'h40C, 32'h11223344, 32'hFFFFFFFF, 0, 4'b1111, 32'h40C, 32'h11223344, 32'h0000007F));
        vecs.push_back(mk(1'b1, 1'b0, 3'b011, 32'h110, 32'h0, 32'h89ABCDEF, 0, 4'b1111, 32'h110, 32'h0, 32'h89ABCDEF));
        vecs.push_back(mk(1'b1, 1'b0, 3'b110, 32'h114, 32'h0, 32'h01020304, 0, 4'b1111, 32'h114, 32'h0, 32'h01020304));
`ifndef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b1, 1'b0, F3_LW,  32'h101, 32'h0, 32'h13572468, 0, 4'b1111, 32'h100, 32'h0, 32'h13572468));
        vecs.push_back(mk(1'b1, 1'b0, F3_LH,  32'h203, 32'h0, 32'hC0DE1234, 0, 4'b1100, 32'h200, 32'h0, 32'hFFFFC0DE));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_we", {31'h0, bus_we}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_be", {28'h0, bus_be}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_fault", {31'h0, Fault}, 32'h0);
        chk("rst_stall", {31'h0, Stall}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // No memory request: no stall, no bus activity
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("nomem_stall", {31'h0, Stall}, 32'h0);
            chk("nomem_req", {31'h0, bus_req}, 32'h0);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word load traps without touching the bus
        @(negedge clk);
        MemRead = 1'b1; funct3 = F3_LW; Mem_WrAddr = 32'h101; bus_rdata = 32'h77777777;
        #1;
        chk("trap_idle_stall", {31'h0, Stall}, 32'h1);
        chk("trap_idle_req", {31'h0, bus_req}, 32'h0);
        @(negedge clk);
        #1;
        chk("trap_fault", {31'h0, Fault}, 32'h1);
        chk("trap_rdata", ReadData, 32'h0);
        chk("trap_req", {31'h0, bus_req}, 32'h0);
        chk("trap_stall", {31'h0, Stall}, 32'h0);
        MemRead = 1'b0;
        @(negedge clk);
        #1;
        chk("trap_fault_clr", {31'h0, Fault}, 32'h0);
        chk("trap_req_after", {31'h0, bus_req}, 32'h0);
`endif

        // Reset asserted mid-transaction
        @(negedge clk);
        MemRead = 1'b1; funct3 = F3_LW; Mem_WrAddr = 32'h500; bus_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_req_before", {31'h0, bus_req}, 32'h1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req_drop", {31'h0, bus_req}, 32'h0);
        chk("mid_rdata", ReadData, 32'h0);
        chk("mid_be", {28'h0, bus_be}, 32'h0);
        chk("mid_stall", {31'h0, Stall}, 32'h1);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst_req", {31'h0, bus_req}, 32'h0);
            chk("post_rst_stall", {31'h0, Stall}, 32'h0);
        end

        // Fresh request after reset completes normally
        run_vec(mk(1'b1, 1'b0, F3_LBU, 32'h602, 32'h0, 32'h00C30000, 0, 4'b0100, 32'h600, 32'h0, 32'h000000C3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
